// File: rtl/branch_history_unit.sv
// Global-history PHT index generator: speculative GHR at fetch, committed GHR at execute,
// index carried F->D->E. Define GSHARE_XOR_EN to fold pcF into the index (gshare); default is GAg.
module branch_history_unit #(
  parameter int HIST_W = 3,
  parameter int PC_LSB = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       pcF,
  input  logic              branchF,
  input  logic              predTakenF,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic              branchE,
  input  logic              branchTakenE,
  input  logic              branchPredictedE,
  output logic [HIST_W-1:0] phtIdxF,
  output logic [HIST_W-1:0] phtIdxE,
  output logic [HIST_W-1:0] ghr,
  output logic              mispredictE
);

  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [HIST_W-1:0] ghrc_q, ghrc_d;
  logic [HIST_W-1:0] idxd_q, idxd_d;
  logic [HIST_W-1:0] idxe_q, idxe_d;
  logic              vd_q, vd_d;
  logic              ve_q, ve_d;
  logic              unused_pc;

`ifdef GSHARE_XOR_EN
  assign phtIdxF = ghr_q ^ pcF[PC_LSB+HIST_W-1:PC_LSB];
`else
  assign phtIdxF = ghr_q;
`endif
  assign unused_pc = ^pcF;

  assign ghr         = ghr_q;
  assign phtIdxE     = idxe_q;
  assign mispredictE = branchE & ve_q & (branchTakenE != branchPredictedE);

  always_comb begin
    ghr_d  = ghr_q;
    ghrc_d = ghrc_q;
    idxd_d = idxd_q;
    vd_d   = vd_q;
    idxe_d = idxd_q;
    ve_d   = vd_q;

    // Shifting only on an unstalled fetch gives one shift per branch regardless of stall length.
    if (branchF && !stallF)
      ghr_d = {ghr_q[HIST_W-2:0], predTakenF};
    // Recovery wins: the same-cycle fetched branch is on the wrong path.
    if (mispredictE)
      ghr_d = {ghrc_q[HIST_W-2:0], branchTakenE};

    if (branchE && ve_q)
      ghrc_d = {ghrc_q[HIST_W-2:0], branchTakenE};

    if (flushD) begin
      idxd_d = '0;
      vd_d   = 1'b0;
    end else if (!stallD) begin
      idxd_d = phtIdxF;
      vd_d   = branchF;
    end

    if (flushE) begin
      idxe_d = '0;
      ve_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q  <= '0;
      ghrc_q <= '0;
      idxd_q <= '0;
      idxe_q <= '0;
      vd_q   <= 1'b0;
      ve_q   <= 1'b0;
    end else begin
      ghr_q  <= ghr_d;
      ghrc_q <= ghrc_d;
      idxd_q <= idxd_d;
      idxe_q <= idxe_d;
      vd_q   <= vd_d;
      ve_q   <= ve_d;
    end
  end

endmodule

// File: tb/tb_branch_history_unit.sv
// Bench for branch_history_unit: directed scenarios with literal expectations plus a
// history/pipeline model compared every cycle. Honours GSHARE_XOR_EN like the design.
module tb_branch_history_unit;
  localparam int HIST_W = 3;
  localparam int PC_LSB = 2;
  localparam int HM     = 1 << HIST_W;

  logic              clk = 1'b0;
  logic              reset, branchF, predTakenF, stallF, stallD, flushD, flushE;
  logic              branchE, branchTakenE, branchPredictedE;
  logic [31:0]       pcF;
  logic [HIST_W-1:0] phtIdxF, phtIdxE, ghr;
  logic              mispredictE;

  int n_tot  = 0;
  int n_pass = 0;

  // Model state: histories as small integers, pipeline as stage arrays (1 = D, 2 = E).
  int m_ghr, m_ghrc;
  int m_idx [1:2];
  bit m_v   [1:2];
  bit men = 1'b0;

  branch_history_unit #(.HIST_W(HIST_W), .PC_LSB(PC_LSB)) dut (
    .clk(clk), .reset(reset), .pcF(pcF), .branchF(branchF), .predTakenF(predTakenF),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .branchE(branchE), .branchTakenE(branchTakenE), .branchPredictedE(branchPredictedE),
    .phtIdxF(phtIdxF), .phtIdxE(phtIdxE), .ghr(ghr), .mispredictE(mispredictE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int fetch_idx();
`ifdef GSHARE_XOR_EN
    int pcb;
    pcb = int'((pcF >> PC_LSB) & 32'(HM - 1));
    return m_ghr ^ pcb;
`else
    return m_ghr;
`endif
  endfunction

  function automatic bit model_mis();
    return branchE && m_v[2] && (branchTakenE != branchPredictedE);
  endfunction

  task automatic model_step();
    int ng;
    int f;
    bit mis;
    mis = model_mis();
    f   = fetch_idx();
    if (reset) begin
      m_ghr = 0; m_ghrc = 0;
      m_idx[1] = 0; m_idx[2] = 0; m_v[1] = 0; m_v[2] = 0;
      men = 1'b1;
    end else begin
      ng = m_ghr;
      if (branchF && !stallF) ng = (m_ghr * 2 + int'(predTakenF)) % HM;
      if (mis) ng = (m_ghrc * 2 + int'(branchTakenE)) % HM;
      if (branchE && m_v[2]) m_ghrc = (m_ghrc * 2 + int'(branchTakenE)) % HM;
      m_ghr = ng;
      if (flushE) begin m_idx[2] = 0; m_v[2] = 0; end
      else begin m_idx[2] = m_idx[1]; m_v[2] = m_v[1]; end
      if (flushD) begin m_idx[1] = 0; m_v[1] = 0; end
      else if (!stallD) begin m_idx[1] = f; m_v[1] = branchF; end
    end
  endtask

  // Inputs change 2 time units after the edge; the model steps on the edge with the DUT.
  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic idle();
    reset = 0; branchF = 0; predTakenF = 0; stallF = 0; stallD = 0; flushD = 0;
    flushE = 0; branchE = 0; branchTakenE = 0; branchPredictedE = 0; pcF = '0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (men) begin
        chk("ghr", int'(ghr), m_ghr);
        chk("phtIdxF", int'(phtIdxF), fetch_idx());
        chk("phtIdxE", int'(phtIdxE), m_idx[2]);
        chk("mispredictE", int'(mispredictE), int'(model_mis()));
      end
    end
  end

  initial begin
    idle();
    reset = 1;
    #2;
    tick(); tick();
    reset = 0;
    chk("reset ghr", int'(ghr), 0);
    chk("reset phtIdxE", int'(phtIdxE), 0);
    chk("reset phtIdxF", int'(phtIdxF), 0);
    chk("reset mispredictE", int'(mispredictE), 0);

    // Three predicted-taken branches fill the history with ones.
    branchF = 1; predTakenF = 1;
    tick(); chk("t1 ghr 001", int'(ghr), 1);
    tick(); chk("t1 ghr 011", int'(ghr), 3);
    tick(); chk("t1 ghr 111", int'(ghr), 7);

    // Steer ghr to 101, then follow that index down to E.
    predTakenF = 0; tick();
    predTakenF = 1; tick();
    chk("t2 phtIdxF 101", int'(phtIdxF), 5);
    predTakenF = 0; tick();
    tick();
    chk("t2 phtIdxE 101", int'(phtIdxE), 5);

    // Commit 0,1,0 so committed history is 010.
    branchE = 1;
    branchTakenE = 0; branchPredictedE = 0; tick();
    branchTakenE = 1; branchPredictedE = 1; tick();
    branchTakenE = 0; branchPredictedE = 0; tick();
    branchTakenE = 1; branchPredictedE = 0; predTakenF = 0;
    #1 chk("t3 mispredictE", int'(mispredictE), 1);
    tick();
    chk("t3 ghr recovered 101", int'(ghr), 5);
    // A second recovery exposes committed history 101 -> {01,0}.
    branchTakenE = 0; branchPredictedE = 1;
    tick();
    chk("t3 ghr from ghrC 010", int'(ghr), 2);

    // Fetch of a branch held for three cycles shifts once.
    branchE = 0; branchTakenE = 0; branchPredictedE = 0;
    branchF = 1; predTakenF = 1; stallF = 1; stallD = 1; flushE = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4 ghr held", int'(ghr), 2);
    end
    chk("t4 phtIdxE bubble", int'(phtIdxE), 0);
    stallF = 0; stallD = 0; flushE = 0;
    tick();
    chk("t4 ghr single shift", int'(ghr), 5);

    // A bubble in E suppresses mispredict and commit.
    branchF = 0; flushE = 1;
    tick();
    flushE = 0; branchE = 1; branchTakenE = 1; branchPredictedE = 0;
    #1 chk("t5 mispredictE bubble", int'(mispredictE), 0);
    tick();
    chk("t5 ghr unchanged", int'(ghr), 5);

    // Bring ghr to 011 and apply pcF = 0x14.
    branchE = 0; branchTakenE = 0; branchF = 1; predTakenF = 1;
    tick();
    branchF = 0; pcF = 32'h14;
    #1 chk("t6 ghr 011", int'(ghr), 3);
`ifdef GSHARE_XOR_EN
    chk("t6 phtIdxF gshare", int'(phtIdxF), 6);
`else
    chk("t6 phtIdxF GAg", int'(phtIdxF), 3);
`endif

    // Reset mid-stream discards in-flight state.
    pcF = '0; branchF = 1; predTakenF = 1;
    tick(); tick();
    reset = 1; tick(); reset = 0; branchF = 0;
    chk("midreset ghr", int'(ghr), 0);
    chk("midreset phtIdxE", int'(phtIdxE), 0);

    // Mixed traffic checked by the model every cycle.
    for (int i = 0; i < 300; i++) begin
      branchF          = 1'($urandom_range(0, 1));
      predTakenF       = 1'($urandom_range(0, 1));
      stallF           = ($urandom_range(0, 3) == 0);
      stallD           = stallF;
      flushD           = ($urandom_range(0, 7) == 0);
      flushE           = stallD | ($urandom_range(0, 7) == 0);
      branchE          = 1'($urandom_range(0, 1));
      branchTakenE     = 1'($urandom_range(0, 1));
      branchPredictedE = 1'($urandom_range(0, 1));
      pcF              = $urandom;
      reset            = ($urandom_range(0, 59) == 0);
      tick();
    end
    idle();
    tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
